// File: rtl/mem_map_pkg.sv
// Shared memory map for the data-side responder: MMIO window, register slots,
// STATUS bit positions and the byte-lane merge helper.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1FAF_0000;

  // Word slots inside the 16-byte window, selected by MemAddrM[3:2]
  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_CMP    = 2'd1;
  localparam logic [1:0] REG_LED    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int STATUS_IRQ_BIT    = 0;
  localparam int STATUS_BUSERR_BIT = 1;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_RAM  = 2'd1,
    RD_MMIO = 2'd2
  } rd_src_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  wen);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running COUNT with compare interrupt, LED register and W1C STATUS.
// Read data is combinational; the top registers it.
module mmio_timer
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  wen,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  input  logic        err_set,
  output logic [31:0] rdata,
  output logic        timer_int,
  output logic [15:0] led,
  output logic        bus_err
);

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [15:0] led_q, led_d;
  logic        irq_q, irq_d;
  logic        bus_err_q, bus_err_d;

  logic wr_count, wr_cmp, wr_led, w1c, match;

  always_comb begin
    wr_count = we && (reg_sel == REG_COUNT);
    wr_cmp   = we && (reg_sel == REG_CMP);
    wr_led   = we && (reg_sel == REG_LED);
    w1c      = we && (reg_sel == REG_STATUS) && wen[0];
    match    = (cmp_q != 32'd0) && (count_q == cmp_q);

    count_d = wr_count ? merge_lanes(count_q, wdata, wen) : count_q + 32'd1;
    cmp_d   = wr_cmp ? merge_lanes(cmp_q, wdata, wen) : cmp_q;

    led_d = led_q;
    if (wr_led && wen[0]) led_d[7:0]  = wdata[7:0];
    if (wr_led && wen[1]) led_d[15:8] = wdata[15:8];

    // A CMP write re-arms the timer, swallowing any match in the same cycle
    irq_d = irq_q;
    if (wr_cmp)                               irq_d = 1'b0;
    else if (match)                           irq_d = 1'b1;
    else if (w1c && wdata[STATUS_IRQ_BIT])    irq_d = 1'b0;

    bus_err_d = bus_err_q;
    if (err_set)                              bus_err_d = 1'b1;
    else if (w1c && wdata[STATUS_BUSERR_BIT]) bus_err_d = 1'b0;

    rdata = 32'd0;
    case (reg_sel)
      REG_COUNT:  rdata = count_q;
      REG_CMP:    rdata = cmp_q;
      REG_LED:    rdata = {16'd0, led_q};
      default: begin
        rdata[STATUS_IRQ_BIT]    = irq_q;
        rdata[STATUS_BUSERR_BIT] = bus_err_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= 32'd0;
      cmp_q     <= 32'd0;
      led_q     <= 16'd0;
      irq_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      led_q     <= led_d;
      irq_q     <= irq_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign timer_int = irq_q;
  assign led       = led_q;
  assign bus_err   = bus_err_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-cycle data-memory responder: byte-laned RAM, MMIO timer window and
// decode-error reporting, with registered read data.
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemEnableM,
  input  logic [3:0]  MemWenM,
  input  logic [31:0] MemAddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        TimerInt,
  output logic [15:0] Led,
  output logic        BusErr
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic          req_ok, is_write, ram_hit, mmio_hit, ram_re, mmio_we, err_set;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_rdata, mmio_rdata;
  logic [31:0]   mmio_rd_q, mmio_rd_d;
  rd_src_e       rd_src_q, rd_src_d;
  logic          addr_unused;

  assign addr_unused = ^MemAddrM[1:0];

  always_comb begin
    // Requests arriving while reset is held must not touch the RAM either
    req_ok   = MemEnableM && rst;
    is_write = |MemWenM;
    ram_hit  = {2'b00, MemAddrM[31:2]} < DEPTH_WORDS;
    mmio_hit = !ram_hit && (MemAddrM[31:4] == MMIO_BASE[31:4]);
    ram_idx  = MemAddrM[AW+1:2];
    ram_we   = (req_ok && ram_hit) ? MemWenM : 4'b0000;
    ram_re   = req_ok && ram_hit && !is_write;
    mmio_we  = req_ok && mmio_hit && is_write;
    err_set  = req_ok && !ram_hit && !mmio_hit;

    rd_src_d  = rd_src_q;
    mmio_rd_d = mmio_rd_q;
    if (req_ok && !is_write) begin
      if (ram_hit)       rd_src_d = RD_RAM;
      else if (mmio_hit) rd_src_d = RD_MMIO;
      else               rd_src_d = RD_NONE;
      if (mmio_hit) mmio_rd_d = mmio_rdata;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_byte_q;
      always_ff @(posedge clk) begin
        if (ram_we[gi]) mem[ram_idx] <= WriteDataM[gi*8 +: 8];
        if (ram_re)     rd_byte_q    <= mem[ram_idx];
      end
      assign ram_rdata[gi*8 +: 8] = rd_byte_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_src_q  <= RD_NONE;
      mmio_rd_q <= 32'd0;
    end else begin
      rd_src_q  <= rd_src_d;
      mmio_rd_q <= mmio_rd_d;
    end
  end

  always_comb begin
    case (rd_src_q)
      RD_RAM:  ReadDataM = ram_rdata;
      RD_MMIO: ReadDataM = mmio_rd_q;
      default: ReadDataM = 32'd0;
    endcase
  end

  mmio_timer u_mmio_timer (
    .clk       (clk),
    .rst       (rst),
    .we        (mmio_we),
    .wen       (MemWenM),
    .reg_sel   (MemAddrM[3:2]),
    .wdata     (WriteDataM),
    .err_set   (err_set),
    .rdata     (mmio_rdata),
    .timer_int (TimerInt),
    .led       (Led),
    .bus_err   (BusErr)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM lanes, decode errors, timer,
// W1C status and asynchronous reset behaviour.
module tb_data_mem_responder;
  import mem_map_pkg::*;

  localparam logic [31:0] BASE = MMIO_BASE_DEFAULT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemEnableM = 1'b0;
  logic [3:0]  MemWenM = 4'b0;
  logic [31:0] MemAddrM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic [31:0] ReadDataM;
  logic        TimerInt;
  logic [15:0] Led;
  logic        BusErr;

  int checks = 0;
  int failures = 0;
  int n;

  data_mem_responder #(.DEPTH_WORDS(4096), .MMIO_BASE(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemEnableM (MemEnableM),
    .MemWenM    (MemWenM),
    .MemAddrM   (MemAddrM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .TimerInt   (TimerInt),
    .Led        (Led),
    .BusErr     (BusErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s got=%08h t=%0t", tag, got, $time);
    end
  endtask

  // One request, presented for exactly one rising edge; returns 1 time unit after it
  task automatic bus_op(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    MemEnableM = 1'b1;
    MemWenM    = wen;
    MemAddrM   = addr;
    WriteDataM = wdata;
    @(posedge clk);
    #1;
    MemEnableM = 1'b0;
    MemWenM    = 4'b0;
  endtask

  task automatic wait_irq(input int limit);
    n = 0;
    while (TimerInt !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", ReadDataM, 32'd0);
    check("rst_irq", 32'(TimerInt), 32'd0);
    check("rst_led", 32'(Led), 32'd0);
    check("rst_buserr", 32'(BusErr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Byte-lane merge and registered read
    bus_op(4'b1111, 32'h100, 32'hA1B2C3D4);
    bus_op(4'b0010, 32'h100, 32'h0000EE00);
    bus_op(4'b0000, 32'h100, 32'h0);
    check("ram_lane_merge", ReadDataM, 32'hA1B2EED4);
    @(posedge clk); #1;
    check("hold_idle", ReadDataM, 32'hA1B2EED4);
    bus_op(4'b1111, 32'h104, 32'h11112222);
    check("hold_write", ReadDataM, 32'hA1B2EED4);
    bus_op(4'b0000, 32'h106, 32'h0);
    check("ram_low_bits_ignored", ReadDataM, 32'h11112222);

    // RAM top boundary and first out-of-range word
    bus_op(4'b1111, 32'h3FFC, 32'hCAFEF00D);
    bus_op(4'b0000, 32'h3FFC, 32'h0);
    check("ram_last_word", ReadDataM, 32'hCAFEF00D);
    bus_op(4'b0000, 32'h4000, 32'h0);
    check("err_read_zero", ReadDataM, 32'd0);
    check("err_buserr_set", 32'(BusErr), 32'd1);
    bus_op(4'b0000, BASE + 32'hC, 32'h0);
    check("status_buserr", ReadDataM, 32'h2);
    bus_op(4'b0001, BASE + 32'hC, 32'h2);
    check("buserr_w1c", 32'(BusErr), 32'd0);

    bus_op(4'b0000, 32'h100, 32'h0);
    bus_op(4'b0000, 32'h0800_0000, 32'h0);
    check("err_far_read_zero", ReadDataM, 32'd0);
    check("err_far_buserr", 32'(BusErr), 32'd1);
    bus_op(4'b0001, BASE + 32'hC, 32'h2);
    check("buserr_clear2", 32'(BusErr), 32'd0);

    // LED keeps only the low half-word
    bus_op(4'b1111, BASE + 32'h8, 32'hFFFF00FF);
    check("led_out", 32'(Led), 32'h0000_00FF);
    bus_op(4'b0000, BASE + 32'h8, 32'h0);
    check("led_read", ReadDataM, 32'h0000_00FF);

    // COUNT write wins over increment; wrap through zero
    bus_op(4'b1111, BASE + 32'h0, 32'h0000_1234);
    bus_op(4'b0000, BASE + 32'h0, 32'h0);
    check("count_readback", ReadDataM, 32'h0000_1234);
    bus_op(4'b1111, BASE + 32'h0, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_op(4'b0000, BASE + 32'h0, 32'h0);
    check("count_wrap", ReadDataM, 32'h0000_0000);

    // Timer: CMP=20, COUNT=0 -> irq 21 cycles after the COUNT write
    bus_op(4'b1111, BASE + 32'h4, 32'd20);
    bus_op(4'b1111, BASE + 32'h0, 32'd0);
    wait_irq(40);
    check("irq_latency", 32'(n), 32'd21);
    bus_op(4'b0000, BASE + 32'hC, 32'h0);
    check("status_irq", ReadDataM, 32'h1);
    bus_op(4'b1111, BASE + 32'h4, 32'd20);
    check("irq_cmp_write_clears", 32'(TimerInt), 32'd0);
    bus_op(4'b1111, BASE + 32'h0, 32'd19);
    wait_irq(10);
    check("irq_rearm", 32'(TimerInt), 32'd1);
    bus_op(4'b0001, BASE + 32'hC, 32'h1);
    check("irq_w1c", 32'(TimerInt), 32'd0);

    // Build up a busy state, then hit reset between clock edges
    bus_op(4'b1111, BASE + 32'h0, 32'd19);
    bus_op(4'b0000, BASE + 32'h8, 32'h0);
    bus_op(4'b1111, 32'h0800_0000, 32'h5555_5555);
    wait_irq(10);
    check("pre_rst_irq", 32'(TimerInt), 32'd1);
    check("pre_rst_led", 32'(Led), 32'h0000_00FF);
    check("pre_rst_buserr", 32'(BusErr), 32'd1);
    check("err_write_hold", ReadDataM, 32'h0000_00FF);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_rdata", ReadDataM, 32'd0);
    check("async_rst_irq", 32'(TimerInt), 32'd0);
    check("async_rst_led", 32'(Led), 32'd0);
    check("async_rst_buserr", 32'(BusErr), 32'd0);
    bus_op(4'b1111, 32'h100, 32'h0BAD_0BAD);
    bus_op(4'b1111, BASE + 32'h8, 32'h0000_1111);
    check("rst_ignores_led_write", 32'(Led), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus_op(4'b0000, 32'h100, 32'h0);
    check("ram_survives_rst", ReadDataM, 32'hA1B2EED4);
    bus_op(4'b0000, BASE + 32'h4, 32'h0);
    check("cmp_after_rst", ReadDataM, 32'd0);
    bus_op(4'b0000, BASE + 32'hC, 32'h0);
    check("status_after_rst", ReadDataM, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, RAM size in 32-bit words (16 KB).
REQ-002 SHALL have parameter MMIO_BASE, default 32'h1FAF_0000, base of the 16-byte register window.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MemEnableM  input  1  request valid this cycle.
REQ-006 SHALL have port MemWenM  input  4  byte-lane write enables; 4'b0000 with MemEnableM means read.
REQ-007 SHALL have port MemAddrM  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port WriteDataM  input  32  write data, lane-aligned.
REQ-009 SHALL have port ReadDataM  output  32  read data.
REQ-010 SHALL have port TimerInt  output  1  level interrupt, wired to CPU Int[5].
REQ-011 SHALL have port Led  output  16  LED register contents.
REQ-012 SHALL have port BusErr  output  1  sticky decode-error flag.

Function
REQ-013 SHALL decode: RAM when MemAddrM[31:2] < DEPTH_WORDS; MMIO when MemAddrM[31:4] == MMIO_BASE[31:4]; otherwise error.
REQ-014 SHALL write only enabled byte lanes, on the request edge, for RAM and MMIO targets.
REQ-015 SHALL register ReadDataM: read issued in cycle N is valid from cycle N+1 until the next read, for every target.
REQ-016 SHALL hold ReadDataM unchanged on idle cycles and on write cycles.
REQ-017 SHALL return 32'h0 on error reads, set BusErr and drop error writes.
REQ-018 SHALL place MMIO registers at offsets 0x0 COUNT, 0x4 CMP, 0x8 LED (bits 15:0), 0xC STATUS (bit0 irq pending, bit1 BusErr).
REQ-019 SHALL increment COUNT by 1 every cycle with 32-bit wrap from 32'hFFFF_FFFF to 0.
REQ-020 SHALL give a COUNT write priority over the increment, so the written value is read back on the next cycle and increments from there.
REQ-021 SHALL set irq pending in the cycle after COUNT == CMP when CMP != 0; CMP == 0 disables the timer.
REQ-022 SHALL clear irq pending on any CMP write; a match that coincides with a CMP write is discarded.
REQ-023 SHALL clear STATUS bits by writing 1 on lane 0 (W1C); a set and a clear in the same cycle leaves the bit set.
REQ-024 SHALL drive TimerInt equal to irq pending and BusErr equal to STATUS bit1.
REQ-025 SHALL return reads of LED with bits 31:16 = 0 and of STATUS with bits 31:2 = 0.
REQ-026 SHALL serve one request per cycle with no stall and no back-pressure.

Reset
REQ-027 SHALL, while rst is low, force ReadDataM = 0, COUNT = 0, CMP = 0, Led = 0, TimerInt = 0, BusErr = 0.
REQ-028 SHALL not clear RAM contents on reset.
REQ-029 SHALL ignore requests while in reset; the first request after deassertion is served normally.

Structure
REQ-030 SHALL take MMIO_BASE default, register offsets and the STATUS bit positions from shared package mem_map_pkg.
REQ-031 SHALL implement COUNT, CMP, LED and STATUS in sub-module mmio_timer; RAM array and decode stay in the top.

Verification
REQ-032 SHALL cover: write 32'hA1B2C3D4 to 0x100 with MemWenM 4'b1111, then MemWenM 4'b0010 with data 32'h0000EE00, read 0x100 -> 32'hA1B2EED4 on the cycle after the read.
REQ-033 SHALL cover: write CMP = 20, COUNT = 0 -> TimerInt rises exactly 21 cycles after the COUNT write; a CMP write drops it the next cycle.
REQ-034 SHALL cover: write COUNT = 32'hFFFF_FFFE, read COUNT two cycles later -> value 32'h0000_0000.
REQ-035 SHALL cover: read 0x0800_0000 -> ReadDataM = 0, BusErr = 1; write 32'h2 to STATUS -> BusErr = 0.
REQ-036 SHALL cover: assert rst mid-stream with TimerInt = 1 and Led = 16'h00FF -> all outputs 0 immediately; RAM word at 0x100 still reads 32'hA1B2EED4.
